// File: rtl/border_pkg.sv
// -----------------------------------------------------------------------------
// border_pkg
// Shared definitions for the border-flag consumers of the video pipeline.
// The background drawer and border_hit_detector both import this package, so
// the meaning of the bordersDR bits and the screen mid-line stay in one place.
//   BORDER_ANY_BIT  : bordersDR bit set on any border line
//   BORDER_ZONE_BIT : bordersDR bit set on the player-zone line only
//   DEFAULT_MID_X   : pixelX split between left and right side hits
// -----------------------------------------------------------------------------
package border_pkg;

  localparam int BORDER_ANY_BIT  = 0;
  localparam int BORDER_ZONE_BIT = 1;
  localparam int DEFAULT_MID_X   = 320;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    COLLECT    = 2'd1,
    REPORT     = 2'd2
  } border_state_e;

  // A pixel counts as a border hit for an object only when the object is
  // drawing, a border line is drawn, and collisions are enabled.
  function automatic logic hit_term(input logic object_dr,
                                    input logic border_any,
                                    input logic collision_enable);
    return object_dr & border_any & collision_enable;
  endfunction

endpackage

// File: rtl/border_hit_slice.sv
// -----------------------------------------------------------------------------
// border_hit_slice
// Per-object border-hit accumulator. Collects hit / player-zone / first-hit
// side over one frame and turns them into a one-cycle registered report when
// the frame closes.
//   clk, resetN      : clock, asynchronous active-low reset
//   acc_en           : accumulation active this cycle (COLLECT or REPORT)
//   acc_clr          : clear accumulators (first startOfFrame after reset)
//   frame_close      : startOfFrame while accumulating; report and restart
//   object_dr        : this object's draw request
//   border_any       : any-border flag
//   border_zone      : player-zone-line flag
//   collision_enable : hits are ignored while low
//   is_left          : current pixelX lies left of the mid-line
//   hit_pulse        : registered one-cycle hit report
//   hit_zone         : registered player-zone report (valid with hit_pulse)
//   hit_left         : registered first-hit side report (valid with hit_pulse)
// -----------------------------------------------------------------------------
module border_hit_slice
  import border_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  input  logic acc_en,
  input  logic acc_clr,
  input  logic frame_close,
  input  logic object_dr,
  input  logic border_any,
  input  logic border_zone,
  input  logic collision_enable,
  input  logic is_left,
  output logic hit_pulse,
  output logic hit_zone,
  output logic hit_left
);

  logic hit_s;
  logic acc_hit_d,  acc_hit_q;
  logic acc_zone_d, acc_zone_q;
  logic acc_left_d, acc_left_q;
  logic pulse_d,    pulse_q;
  logic zone_d,     zone_q;
  logic left_d,     left_q;

  assign hit_s = acc_en & hit_term(object_dr, border_any, collision_enable);

  // Next-state of accumulators and report registers.
  always_comb begin
    acc_hit_d  = acc_hit_q;
    acc_zone_d = acc_zone_q;
    acc_left_d = acc_left_q;
    pulse_d    = 1'b0;
    zone_d     = 1'b0;
    left_d     = 1'b0;
    if (acc_clr) begin
      acc_hit_d  = 1'b0;
      acc_zone_d = 1'b0;
      acc_left_d = 1'b0;
    end else if (frame_close) begin
      // Report the closed frame; a hit in this same cycle opens the new one.
      pulse_d    = acc_hit_q;
      zone_d     = acc_zone_q;
      left_d     = acc_left_q;
      acc_hit_d  = hit_s;
      acc_zone_d = hit_s & border_zone;
      acc_left_d = hit_s & is_left;
    end else begin
      acc_hit_d  = acc_hit_q | hit_s;
      acc_zone_d = acc_zone_q | (hit_s & border_zone);
      // Side is latched only by the first hit of the frame.
      if (hit_s && !acc_hit_q) begin
        acc_left_d = is_left;
      end else begin
        acc_left_d = acc_left_q;
      end
    end
  end

  // Accumulator and report registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc_hit_q  <= 1'b0;
      acc_zone_q <= 1'b0;
      acc_left_q <= 1'b0;
      pulse_q    <= 1'b0;
      zone_q     <= 1'b0;
      left_q     <= 1'b0;
    end else begin
      acc_hit_q  <= acc_hit_d;
      acc_zone_q <= acc_zone_d;
      acc_left_q <= acc_left_d;
      pulse_q    <= pulse_d;
      zone_q     <= zone_d;
      left_q     <= left_d;
    end
  end

  assign hit_pulse = pulse_q;
  assign hit_zone  = zone_q;
  assign hit_left  = left_q;

endmodule

// File: rtl/border_hit_detector.sv
// -----------------------------------------------------------------------------
// border_hit_detector
// Correlates the background's border flags with per-object draw requests and
// reports, once per frame, which objects touched a border line.
//   clk, resetN     : clock, asynchronous active-low reset
//   startOfFrame    : one-cycle pulse at the start of every frame
//   collisionEnable : when low, no new hits are accumulated
//   pixelX          : current pixel X, aligned with the draw requests
//   bordersDR       : bit0 any border line, bit1 player-zone line
//   objectDR        : per-object draw requests
//   hitPulse        : one-cycle pulse per object that hit a border last frame
//   hitPlayerZone   : valid with hitPulse, object touched the player-zone line
//   hitLeft         : valid with hitPulse, first hit was left of MID_X
//   frameValid      : set once a full frame has been observed since reset
//   hitX            : (HIT_COORD_CAPTURE_EN only) pixelX of object 0's first
//                     hit in the reported frame, valid with hitPulse[0]
// Optional feature macro: HIT_COORD_CAPTURE_EN
// -----------------------------------------------------------------------------
module border_hit_detector
  import border_pkg::*;
#(
  parameter int NUM_OBJECTS = 4,
  parameter int PIXEL_WIDTH = 11,
  parameter int MID_X       = DEFAULT_MID_X
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   collisionEnable,
  input  logic [PIXEL_WIDTH-1:0] pixelX,
  input  logic [1:0]             bordersDR,
  input  logic [NUM_OBJECTS-1:0] objectDR,
  output logic [NUM_OBJECTS-1:0] hitPulse,
  output logic [NUM_OBJECTS-1:0] hitPlayerZone,
  output logic [NUM_OBJECTS-1:0] hitLeft,
`ifdef HIT_COORD_CAPTURE_EN
  output logic [PIXEL_WIDTH-1:0] hitX,
`endif
  output logic                   frameValid
);

  localparam logic [PIXEL_WIDTH-1:0] MID_X_C = PIXEL_WIDTH'(MID_X);

  border_state_e state_d, state_q;
  logic          frame_valid_d, frame_valid_q;
  logic          acc_en_s;
  logic          acc_clr_s;
  logic          frame_close_s;
  logic          is_left_s;

  assign acc_en_s      = (state_q == COLLECT) || (state_q == REPORT);
  assign acc_clr_s     = startOfFrame && (state_q == WAIT_FRAME);
  assign frame_close_s = startOfFrame && acc_en_s;
  assign is_left_s     = (pixelX < MID_X_C);

  // Frame state machine next-state and frameValid latch.
  always_comb begin
    state_d       = state_q;
    frame_valid_d = frame_valid_q | frame_close_s;
    case (state_q)
      WAIT_FRAME: begin
        if (startOfFrame) state_d = COLLECT;
        else              state_d = WAIT_FRAME;
      end
      COLLECT: begin
        if (startOfFrame) state_d = REPORT;
        else              state_d = COLLECT;
      end
      REPORT: begin
        // A startOfFrame here closes a one-cycle frame and reports again.
        if (startOfFrame) state_d = REPORT;
        else              state_d = COLLECT;
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  // State and frameValid registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= WAIT_FRAME;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign frameValid = frame_valid_q;

  for (genvar i = 0; i < NUM_OBJECTS; i++) begin : g_slice
    border_hit_slice u_slice (
      .clk              (clk),
      .resetN           (resetN),
      .acc_en           (acc_en_s),
      .acc_clr          (acc_clr_s),
      .frame_close      (frame_close_s),
      .object_dr        (objectDR[i]),
      .border_any       (bordersDR[BORDER_ANY_BIT]),
      .border_zone      (bordersDR[BORDER_ZONE_BIT]),
      .collision_enable (collisionEnable),
      .is_left          (is_left_s),
      .hit_pulse        (hitPulse[i]),
      .hit_zone         (hitPlayerZone[i]),
      .hit_left         (hitLeft[i])
    );
  end

`ifdef HIT_COORD_CAPTURE_EN
  logic                   hit0_s;
  logic                   acc_x_seen_d, acc_x_seen_q;
  logic [PIXEL_WIDTH-1:0] acc_x_d, acc_x_q;
  logic [PIXEL_WIDTH-1:0] hit_x_d, hit_x_q;

  assign hit0_s = acc_en_s & hit_term(objectDR[0], bordersDR[BORDER_ANY_BIT],
                                      collisionEnable);

  // Object 0 first-hit coordinate capture and report.
  always_comb begin
    acc_seen_default: begin
      acc_x_seen_d = acc_x_seen_q;
      acc_x_d      = acc_x_q;
      hit_x_d      = {PIXEL_WIDTH{1'b0}};
    end
    if (acc_clr_s) begin
      acc_x_seen_d = 1'b0;
      acc_x_d      = {PIXEL_WIDTH{1'b0}};
    end else if (frame_close_s) begin
      hit_x_d      = acc_x_q;
      acc_x_seen_d = hit0_s;
      acc_x_d      = hit0_s ? pixelX : {PIXEL_WIDTH{1'b0}};
    end else if (hit0_s && !acc_x_seen_q) begin
      acc_x_seen_d = 1'b1;
      acc_x_d      = pixelX;
    end else begin
      acc_x_seen_d = acc_x_seen_q;
      acc_x_d      = acc_x_q;
    end
  end

  // Coordinate capture registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc_x_seen_q <= 1'b0;
      acc_x_q      <= {PIXEL_WIDTH{1'b0}};
      hit_x_q      <= {PIXEL_WIDTH{1'b0}};
    end else begin
      acc_x_seen_q <= acc_x_seen_d;
      acc_x_q      <= acc_x_d;
      hit_x_q      <= hit_x_d;
    end
  end

  assign hitX = hit_x_q;
`endif

endmodule

// File: tb/tb_border_hit_detector.sv
// -----------------------------------------------------------------------------
// tb_border_hit_detector
// Directed frames followed by randomized traffic, checked cycle by cycle
// against a frame-level reference model of the border hit reports.
// Optional feature macro: HIT_COORD_CAPTURE_EN
// -----------------------------------------------------------------------------
module tb_border_hit_detector;

  localparam int N   = 4;
  localparam int PW  = 11;
  localparam int MID = 320;

  logic          clk = 1'b0;
  logic          resetN;
  logic          startOfFrame;
  logic          collisionEnable;
  logic [PW-1:0] pixelX;
  logic [1:0]    bordersDR;
  logic [N-1:0]  objectDR;
  logic [N-1:0]  hitPulse;
  logic [N-1:0]  hitPlayerZone;
  logic [N-1:0]  hitLeft;
  logic          frameValid;
`ifdef HIT_COORD_CAPTURE_EN
  logic [PW-1:0] hitX;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: per-frame record of what each object did so far.
  bit            m_started;
  bit            m_valid;
  bit [N-1:0]    m_hit, m_zone, m_left;
  int            m_x;
  bit [N-1:0]    e_pulse, e_zone, e_left;
  int            e_x;

  always #5 clk = ~clk;

  border_hit_detector #(.NUM_OBJECTS(N), .PIXEL_WIDTH(PW), .MID_X(MID)) dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .collisionEnable (collisionEnable),
    .pixelX          (pixelX),
    .bordersDR       (bordersDR),
    .objectDR        (objectDR),
    .hitPulse        (hitPulse),
    .hitPlayerZone   (hitPlayerZone),
    .hitLeft         (hitLeft),
`ifdef HIT_COORD_CAPTURE_EN
    .hitX            (hitX),
`endif
    .frameValid      (frameValid)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_valid   = 1'b0;
    m_hit     = '0;
    m_zone    = '0;
    m_left    = '0;
    m_x       = 0;
  endtask

  // Applies the frame rules to this cycle's inputs; produces next-cycle outputs.
  task automatic model_cycle(input bit sof, input bit en, input int px,
                             input bit [1:0] bdr, input bit [N-1:0] odr);
    bit [N-1:0] hits;
    hits    = (bdr[0] && en) ? odr : '0;
    e_pulse = '0;
    e_zone  = '0;
    e_left  = '0;
    e_x     = 0;
    if (!m_started) begin
      if (sof) begin
        m_started = 1'b1;
        m_hit = '0; m_zone = '0; m_left = '0; m_x = 0;
      end
    end else if (sof) begin
      e_pulse = m_hit;
      e_zone  = m_zone;
      e_left  = m_left;
      e_x     = m_x;
      m_valid = 1'b1;
      m_hit = '0; m_zone = '0; m_left = '0; m_x = 0;
      for (int i = 0; i < N; i++) begin
        if (hits[i]) begin
          m_hit[i]  = 1'b1;
          m_zone[i] = bdr[1];
          m_left[i] = (px < MID);
          if (i == 0) m_x = px;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (hits[i]) begin
          if (!m_hit[i]) begin
            m_left[i] = (px < MID);
            if (i == 0) m_x = px;
          end
          m_hit[i] = 1'b1;
          if (bdr[1]) m_zone[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_outputs(input string tag);
    check_eq({tag, "_pulse"}, 32'(hitPulse), 32'(e_pulse));
    check_eq({tag, "_zone"}, 32'(hitPlayerZone), 32'(e_zone));
    check_eq({tag, "_left"}, 32'(hitLeft), 32'(e_left));
    check_eq({tag, "_valid"}, 32'(frameValid), 32'(m_valid));
`ifdef HIT_COORD_CAPTURE_EN
    check_eq({tag, "_x"}, 32'(hitX), 32'(e_x));
`endif
  endtask

  // One clock cycle: drive, predict, clock, compare.
  task automatic step(input string tag, input bit sof, input bit en,
                      input int px, input bit [1:0] bdr, input bit [N-1:0] odr);
    startOfFrame    = sof;
    collisionEnable = en;
    pixelX          = PW'(px);
    bordersDR       = bdr;
    objectDR        = odr;
    model_cycle(sof, en, px, bdr, odr);
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 1'b0, 1'b1, 100, 2'b00, '0);
  endtask

  task automatic do_reset(input string tag);
    resetN = 1'b0;
    model_reset();
    e_pulse = '0; e_zone = '0; e_left = '0; e_x = 0;
    #2;
    compare_outputs(tag);
    @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b1;
    startOfFrame = 1'b0; collisionEnable = 1'b1; pixelX = '0;
    bordersDR = 2'b00; objectDR = '0;
    model_reset();
    #1;
    do_reset("rst");

    // Two empty frames: no pulses, frameValid rises after the second pulse.
    idle("idle", 3);
    step("sof1", 1'b1, 1'b1, 0, 2'b00, '0);
    check_eq("fv_after_first", 32'(frameValid), 32'd0);
    idle("empty", 5);
    step("sof2", 1'b1, 1'b1, 0, 2'b00, '0);
    check_eq("fv_after_second", 32'(frameValid), 32'd1);

    // Object 0 on a left border for 3 cycles: one pulse, left side.
    for (int k = 0; k < 3; k++) step("o0hit", 1'b0, 1'b1, 20, 2'b01, 4'b0001);
    idle("o0gap", 2);
    step("o0sof", 1'b1, 1'b1, 0, 2'b00, '0);
    check_eq("o0_pulse", 32'(hitPulse), 32'h1);
    check_eq("o0_left", 32'(hitLeft), 32'h1);
    check_eq("o0_zone", 32'(hitPlayerZone), 32'h0);
    step("o0after", 1'b0, 1'b1, 0, 2'b00, '0);
    check_eq("o0_width", 32'(hitPulse), 32'h0);

    // Object 2 on the player-zone line on the right side; later left hit ignored.
    step("o2hit", 1'b0, 1'b1, 400, 2'b11, 4'b0100);
    step("o2hit2", 1'b0, 1'b1, 30, 2'b01, 4'b0100);
    step("o2sof", 1'b1, 1'b1, 0, 2'b00, '0);
    check_eq("o2_pulse", 32'(hitPulse), 32'h4);
    check_eq("o2_zone", 32'(hitPlayerZone), 32'h4);
    check_eq("o2_left", 32'(hitLeft), 32'h0);

    // Hit coinciding with startOfFrame belongs to the next frame.
    idle("o1pre", 3);
    step("o1sof", 1'b1, 1'b1, 50, 2'b01, 4'b0010);
    check_eq("o1_not_now", 32'(hitPulse), 32'h0);
    idle("o1mid", 4);
    step("o1sof2", 1'b1, 1'b1, 0, 2'b00, '0);
    check_eq("o1_next", 32'(hitPulse), 32'h2);

    // Reset mid-frame discards hits; next sof gives no pulse.
    step("rhit", 1'b0, 1'b1, 200, 2'b01, 4'b1111);
    do_reset("rst_mid");
    step("rsof", 1'b1, 1'b1, 0, 2'b00, '0);
    check_eq("rst_no_pulse", 32'(hitPulse), 32'h0);
    step("rhit2", 1'b0, 1'b1, 500, 2'b01, 4'b1000);
    step("rsof2", 1'b1, 1'b1, 0, 2'b00, '0);
    check_eq("rst_recover", 32'(hitPulse), 32'h8);

    // Collisions disabled: object 3 ignored; object 0 coordinate capture.
    step("dis", 1'b0, 1'b0, 100, 2'b01, 4'b1000);
    step("x619", 1'b0, 1'b1, 619, 2'b01, 4'b0001);
    step("x10", 1'b0, 1'b1, 10, 2'b01, 4'b0001);
    step("dissof", 1'b1, 1'b1, 0, 2'b00, '0);
    check_eq("dis_pulse", 32'(hitPulse), 32'h1);
`ifdef HIT_COORD_CAPTURE_EN
    check_eq("hitx_619", 32'(hitX), 32'd619);
`endif

    // Back-to-back startOfFrame pulses must not lock up.
    step("b2b1", 1'b1, 1'b1, 5, 2'b01, 4'b0011);
    step("b2b2", 1'b1, 1'b1, 5, 2'b00, '0);
    step("b2b3", 1'b1, 1'b1, 5, 2'b00, '0);
    idle("b2bpost", 3);

    // Randomized traffic with occasional resets and short frames.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd", $urandom_range(0, 24) == 0, $urandom_range(0, 5) != 0,
             int'($urandom_range(0, 639)), 2'($urandom_range(0, 3)),
             N'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
